rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 32768, max instruction words loadable.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_byte  input  8  program stream byte.
REQ-005 SHALL have port in_valid  input  1  in_byte valid this cycle.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid and in_ready both high.
REQ-007 SHALL have port reload  input  1  one-cycle request to restart loading from DONE or ERROR.
REQ-008 SHALL have port rom_we  output  1  instruction-ROM write strobe, one cycle per word.
REQ-009 SHALL have port rom_addr  output  15  instruction-ROM write address.
REQ-010 SHALL have port rom_data  output  16  instruction word to write.
REQ-011 SHALL have port cpu_reset  output  1  drives the computer's reset input; high while not DONE.
REQ-012 SHALL have ports done and error  output  1 each  status flags.

Function
REQ-013 SHALL implement states HDR_HI, HDR_LO, DATA_HI, DATA_LO, DONE, ERROR.
REQ-014 Stream format SHALL be: 16-bit word count N (high byte first), then N instruction words, each high byte first.
REQ-015 in_ready SHALL be high exactly in HDR_HI, HDR_LO, DATA_HI, DATA_LO; low in DONE and ERROR.
REQ-016 HDR_HI: on transfer latch count[15:8], go HDR_LO; no transfer -> stay.
REQ-017 HDR_LO: on transfer form N; N=0 -> DONE; N>ROM_DEPTH -> ERROR; else clear word address to 0, go DATA_HI.
REQ-018 DATA_HI: on transfer latch high byte, go DATA_LO.
REQ-019 DATA_LO: on transfer register rom_data={high,in_byte}, rom_addr=current address, rom_we=1 for the following cycle; increment address; last word (address+1==N) -> DONE, else DATA_HI.
REQ-020 Write latency SHALL be exactly one cycle from low-byte transfer to rom_we high; rom_we high no more than one cycle per word.
REQ-021 Back-to-back bytes (in_valid held high) SHALL be accepted every cycle with no bubbles; N words SHALL take exactly 2N+2 transfer cycles.
REQ-022 Address arithmetic SHALL use 16 bits internally so N=32768 completes with final rom_addr=32767 without wrap; rom_addr SHALL never wrap to 0 mid-load.
REQ-023 cpu_reset SHALL be high in every state except DONE; it SHALL fall in the cycle after the final rom_we pulse (i.e. rom_we and cpu_reset low never overlap in a way that lets the CPU fetch before the last write).
REQ-024 done SHALL be high only in DONE; error SHALL be high only in ERROR.
REQ-025 reload in DONE or ERROR SHALL go to HDR_HI, reassert cpu_reset the next cycle; reload in any loading state SHALL be ignored.
REQ-026 in_valid while in_ready low SHALL be ignored (byte dropped, no state change).

Reset
REQ-027 reset SHALL have priority over reload and transfers; reset mid-load SHALL abandon the partial word, not issue rom_we, and enter HDR_HI.
REQ-028 Reset values SHALL be: state HDR_HI, in_ready 1, rom_we 0, rom_addr 0, rom_data 0, cpu_reset 1, done 0, error 0.

Structure
REQ-029 Shared package rom_loader_pkg SHALL hold the state enumeration and ROM_DEPTH default/address width constants; CPU-side modules SHALL take address width from it.
REQ-030 Block SHALL be a single module with one FSM, byte latch, count and address registers; no sub-module is required.
REQ-031 Top level SHALL wire cpu_reset into the computer's reset and rom_we/rom_addr/rom_data into the ROM write port.

Verification
REQ-032 Stream 00 03, 12 34, AB CD, FF FF continuous -> rom_we at addrs 0,1,2 with 1234, ABCD, FFFF; done=1, cpu_reset=0 the cycle after third write; 8 transfer cycles total.
REQ-033 Stream 00 00 -> DONE immediately after second byte, no rom_we, cpu_reset falls.
REQ-034 Stream 80 01 -> ERROR, error=1, in_ready=0, cpu_reset stays 1; then reload -> HDR_HI, in_ready=1.
REQ-035 Stream 00 02, 11 22 then reset asserted after byte 33 of second word -> no second rom_we, state HDR_HI, cpu_reset=1; fresh stream 00 01 55 66 -> writes 5566 at addr 0.
REQ-036 Random in_valid gaps over N=5 -> identical ROM contents to gap-free run; in_valid in DONE ignored; reload pulsed mid-load ignored.
REQ-037 N=32768 stream of incrementing words -> last rom_we at addr 32767 data 7FFF, done=1, no write to addr 0 after first.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the program-stream ROM loader and the CPU-side blocks
// that consume its write port.
package rom_loader_pkg;

    localparam int unsigned ROM_DEPTH_DEFAULT = 32768;
    localparam int          ADDR_W            = 15;
    localparam int          COUNT_W           = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        DONE,
        ERROR
    } loaderState_t;

endpackage

// File: rtl/rom_loader.sv
// Streams a length-prefixed big-endian program image into the instruction ROM
// and holds the CPU in reset until the final word has been written.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEFAULT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    loaderState_t       state;
    logic [7:0]         hiByte;
    logic [COUNT_W-1:0] wordCount;
    logic [COUNT_W-1:0] wordAddr;
    logic [COUNT_W-1:0] headerCount;
    logic [COUNT_W-1:0] nextAddr;
    logic               xfer;

    assign xfer        = in_valid && in_ready;
    assign headerCount = {wordCount[15:8], in_byte};
    // Word address is a full 16 bits so a maximal image finishes without wrapping.
    assign nextAddr    = wordAddr + 16'd1;

    // cpu_reset is dropped only after one full cycle in DONE, so the CPU can
    // never fetch in the same cycle the last word is still being written.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= HDR_HI;
            in_ready  <= 1'b1;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_data  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            hiByte    <= '0;
            wordCount <= '0;
            wordAddr  <= '0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        wordCount[15:8] <= in_byte;
                        state           <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        wordCount[7:0] <= in_byte;
                        if (headerCount == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else if (32'(headerCount) > ROM_DEPTH) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            wordAddr <= '0;
                            state    <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hiByte <= in_byte;
                        state  <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        rom_we   <= 1'b1;
                        rom_data <= {hiByte, in_byte};
                        rom_addr <= wordAddr[ADDR_W-1:0];
                        wordAddr <= nextAddr;
                        if (nextAddr == wordCount) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state     <= HDR_HI;
                        in_ready  <= 1'b1;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                    end else begin
                        cpu_reset <= 1'b0;
                    end
                end
                ERROR: begin
                    if (reload) begin
                        state    <= HDR_HI;
                        in_ready <= 1'b1;
                        error    <= 1'b0;
                    end
                end
                default: begin
                    state     <= HDR_HI;
                    in_ready  <= 1'b1;
                    cpu_reset <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomised self-checking bench for rom_loader: a byte-counting stream model
// predicts every output each cycle, with literal spot checks on key scenarios.
module tb_rom_loader;

    localparam int DEPTH    = 32768;
    localparam int PH_LOAD  = 0;
    localparam int PH_DONE  = 1;
    localparam int PH_ERR   = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int          mPhase;
    int          mBytes;
    int          mN;
    int          mDoneAge;
    logic [7:0]  mHi;
    logic        mExpWe;
    logic [14:0] mExpAddr;
    logic [15:0] mExpData;

    logic [15:0] dutRom [0:DEPTH-1];
    logic [15:0] wordBuf [0:7];
    logic [15:0] refRom [0:7];
    int writeCount  = 0;
    int addr0Writes = 0;
    int xferCount   = 0;

    rom_loader #(.ROM_DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reload   (reload),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 30)
                $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: counts accepted bytes in the current image and derives
    // status and expected writes from the byte position alone.
    always @(posedge CLK) begin
        if (reset) begin
            mPhase = PH_LOAD; mBytes = 0; mN = 0; mDoneAge = 0; mHi = '0;
            mExpWe = 1'b0; mExpAddr = '0; mExpData = '0;
        end else begin
            mExpWe = 1'b0;
            if (mPhase == PH_LOAD) begin
                if (in_valid) begin
                    mBytes++;
                    if (mBytes == 1) begin
                        mN = int'(in_byte) * 256;
                    end else if (mBytes == 2) begin
                        mN = mN + int'(in_byte);
                        if (mN == 0) begin
                            mPhase = PH_DONE; mDoneAge = 0;
                        end else if (mN > DEPTH) begin
                            mPhase = PH_ERR;
                        end
                    end else if (mBytes % 2 == 1) begin
                        mHi = in_byte;
                    end else begin
                        mExpWe   = 1'b1;
                        mExpAddr = 15'((mBytes - 3) / 2);
                        mExpData = {mHi, in_byte};
                        if ((mBytes - 3) / 2 + 1 == mN) begin
                            mPhase = PH_DONE; mDoneAge = 0;
                        end
                    end
                end
            end else if (mPhase == PH_DONE) begin
                if (reload) begin
                    mPhase = PH_LOAD; mBytes = 0;
                end else begin
                    mDoneAge++;
                end
            end else begin
                if (reload) begin
                    mPhase = PH_LOAD; mBytes = 0;
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (!reset && in_valid && in_ready)
            xferCount++;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("in_ready",  32'(in_ready),  32'(mPhase == PH_LOAD));
            checkOutput("done",      32'(done),      32'(mPhase == PH_DONE));
            checkOutput("error",     32'(error),     32'(mPhase == PH_ERR));
            checkOutput("cpu_reset", 32'(cpu_reset), 32'(!(mPhase == PH_DONE && mDoneAge >= 1)));
            checkOutput("rom_we",    32'(rom_we),    32'(mExpWe));
            checkOutput("rom_addr",  32'(rom_addr),  32'(mExpAddr));
            checkOutput("rom_data",  32'(rom_data),  32'(mExpData));
            if (rom_we) begin
                dutRom[rom_addr] = rom_data;
                writeCount++;
                if (rom_addr == 15'd0) addr0Writes++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            reload   = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(posedge CLK); #1;
        reload = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                reload   = ($urandom_range(0, 3) == 0);
                @(posedge CLK); #1;
            end
        end
        reload   = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [15:0] w, input bit gaps);
        applyStimulus(w[15:8], gaps);
        applyStimulus(w[7:0], gaps);
    endtask

    initial begin
        #1500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int wc;
        reset = 1'b1; in_valid = 1'b0; in_byte = '0; reload = 1'b0;
        @(posedge CLK); #1;
        checkEn = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;

        checkOutput("reset in_ready",  32'(in_ready), 32'd1);
        checkOutput("reset cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reset rom_we",    32'(rom_we), 32'd0);
        checkOutput("reset rom_addr",  32'(rom_addr), 32'd0);
        checkOutput("reset rom_data",  32'(rom_data), 32'd0);
        checkOutput("reset done",      32'(done), 32'd0);
        checkOutput("reset error",     32'(error), 32'd0);
        idle(2);

        $display("[TB] three-word back-to-back image");
        base = xferCount;
        sendWord(16'h0003, 1'b0);
        sendWord(16'h1234, 1'b0);
        sendWord(16'hABCD, 1'b0);
        sendWord(16'hFFFF, 1'b0);
        checkOutput("last write strobe", 32'(rom_we), 32'd1);
        checkOutput("last write addr",   32'(rom_addr), 32'd2);
        checkOutput("last write data",   32'(rom_data), 32'hFFFF);
        checkOutput("cpu held during last write", 32'(cpu_reset), 32'd1);
        checkOutput("model byte count", 32'(mBytes), 32'd8);
        idle(1);
        checkOutput("cpu released", 32'(cpu_reset), 32'd0);
        checkOutput("done after load", 32'(done), 32'd1);
        checkOutput("transfer cycles", 32'(xferCount - base), 32'd8);
        checkOutput("rom word0", 32'(dutRom[0]), 32'h1234);
        checkOutput("rom word1", 32'(dutRom[1]), 32'hABCD);
        checkOutput("rom word2", 32'(dutRom[2]), 32'hFFFF);
        base = xferCount;
        applyStimulus(8'h77, 1'b0);
        applyStimulus(8'h88, 1'b0);
        checkOutput("bytes ignored in done", 32'(xferCount - base), 32'd0);
        checkOutput("still done", 32'(done), 32'd1);

        $display("[TB] empty image");
        pulseReload();
        checkOutput("reload cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reload in_ready", 32'(in_ready), 32'd1);
        wc = writeCount;
        sendWord(16'h0000, 1'b0);
        checkOutput("empty done", 32'(done), 32'd1);
        idle(1);
        checkOutput("empty cpu released", 32'(cpu_reset), 32'd0);
        checkOutput("empty no writes", 32'(writeCount - wc), 32'd0);

        $display("[TB] oversize image");
        pulseReload();
        sendWord(16'h8001, 1'b0);
        checkOutput("oversize error", 32'(error), 32'd1);
        checkOutput("oversize in_ready", 32'(in_ready), 32'd0);
        idle(2);
        checkOutput("oversize cpu held", 32'(cpu_reset), 32'd1);
        pulseReload();
        checkOutput("error reload in_ready", 32'(in_ready), 32'd1);
        checkOutput("error reload flag", 32'(error), 32'd0);

        $display("[TB] reset mid-load");
        sendWord(16'h0002, 1'b0);
        sendWord(16'h1122, 1'b0);
        applyStimulus(8'h33, 1'b0);
        wc = writeCount;
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'h44; reload = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0; in_valid = 1'b0; reload = 1'b0;
        checkOutput("reset drops partial word", 32'(rom_we), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset mid cpu_reset", 32'(cpu_reset), 32'd1);
        idle(1);
        checkOutput("no write after reset", 32'(writeCount - wc), 32'd0);
        sendWord(16'h0001, 1'b0);
        sendWord(16'h5566, 1'b0);
        checkOutput("fresh write addr", 32'(rom_addr), 32'd0);
        checkOutput("fresh write data", 32'(rom_data), 32'h5566);
        idle(1);

        $display("[TB] gapped versus gap-free five-word image");
        for (int i = 0; i < 5; i++) wordBuf[i] = 16'($urandom);
        pulseReload();
        sendWord(16'd5, 1'b0);
        for (int i = 0; i < 5; i++) sendWord(wordBuf[i], 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            refRom[i] = dutRom[i];
            dutRom[i] = '0;
        end
        pulseReload();
        sendWord(16'd5, 1'b1);
        for (int i = 0; i < 5; i++) sendWord(wordBuf[i], 1'b1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("gapped rom matches gap-free", 32'(dutRom[i]), 32'(refRom[i]));
            checkOutput("gapped rom matches stream", 32'(dutRom[i]), 32'(wordBuf[i]));
        end
        checkOutput("gapped done", 32'(done), 32'd1);

        $display("[TB] full-depth image");
        pulseReload();
        base = addr0Writes;
        sendWord(16'h8000, 1'b0);
        for (int i = 0; i < DEPTH; i++) sendWord(16'(i), 1'b0);
        checkOutput("full last addr", 32'(rom_addr), 32'd32767);
        checkOutput("full last data", 32'(rom_data), 32'h7FFF);
        checkOutput("full last strobe", 32'(rom_we), 32'd1);
        idle(1);
        checkOutput("full done", 32'(done), 32'd1);
        checkOutput("full cpu released", 32'(cpu_reset), 32'd0);
        checkOutput("full single addr0 write", 32'(addr0Writes - base), 32'd1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
